// File: rtl/pred_fork_if.sv
// Stream bundle for pred_fork: value and predicate inputs plus the forked outputs.
// The slave modport is the fork itself; the master modport is its environment.
interface pred_fork_if #(
    parameter int VAL_WIDTH  = 32,
    parameter int PORT_COUNT = 2
);
    logic [PORT_COUNT-1:0]           s_pred_in_tdata;
    logic                            s_pred_in_tvalid;
    logic                            s_pred_in_tready;
    logic [VAL_WIDTH-1:0]            s_fork_in_tdata;
    logic                            s_fork_in_tvalid;
    logic                            s_fork_in_tready;
    logic [PORT_COUNT*VAL_WIDTH-1:0] m_fork_out_tdata;
    logic [PORT_COUNT-1:0]           m_fork_out_tvalid;
    logic [PORT_COUNT-1:0]           m_fork_out_tready;

    modport master (
        output s_pred_in_tdata, s_pred_in_tvalid,
        input  s_pred_in_tready,
        output s_fork_in_tdata, s_fork_in_tvalid,
        input  s_fork_in_tready,
        input  m_fork_out_tdata, m_fork_out_tvalid,
        output m_fork_out_tready
    );

    modport slave (
        input  s_pred_in_tdata, s_pred_in_tvalid,
        output s_pred_in_tready,
        input  s_fork_in_tdata, s_fork_in_tvalid,
        output s_fork_in_tready,
        output m_fork_out_tdata, m_fork_out_tvalid,
        input  m_fork_out_tready
    );
endinterface

// File: rtl/pred_fork.sv
// pred_fork: joins a value stream with a predicate-mask stream and eagerly forks
// each value to every output port whose predicate bit is set.
module pred_fork #(
    parameter int VAL_WIDTH  = 32,
    parameter int PORT_COUNT = 2,
    parameter int IF_PRED_IN = 1,
    parameter int FIFO_SIZE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    pred_fork_if.slave  bus,
    output logic [31:0] drop_count
);
    localparam int AW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam int CW = $clog2(FIFO_SIZE + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_SIZE - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_SIZE);

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic push, input logic pop);
        logic [CW-1:0] nxt;
        case ({push, pop})
            2'b10:   nxt = cnt + CW'(1);
            2'b01:   nxt = cnt - CW'(1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    logic [VAL_WIDTH-1:0]  val_mem_r [FIFO_SIZE];
    logic [AW-1:0]         val_wr_r;
    logic [AW-1:0]         val_rd_r;
    logic [CW-1:0]         val_cnt_r;
    logic                  val_ready_s;
    logic                  val_push_s;
    logic                  val_head_valid_s;
    logic [VAL_WIDTH-1:0]  val_head_s;

    logic [PORT_COUNT-1:0] pred_head_s;
    logic                  pred_head_valid_s;
    logic [PORT_COUNT-1:0] pend_s;
    logic [PORT_COUNT-1:0] done_r;
    logic                  join_valid_s;
    logic                  retire_s;

    assign val_ready_s          = (val_cnt_r != CNT_FULL);
    assign bus.s_fork_in_tready = val_ready_s;
    assign val_push_s           = bus.s_fork_in_tvalid & val_ready_s;
    assign val_head_valid_s     = (val_cnt_r != {CW{1'b0}});
    assign val_head_s           = val_mem_r[val_rd_r];

    // Value FIFO storage write
    always_ff @(posedge clk) begin
        if (val_push_s) begin
            val_mem_r[val_wr_r] <= bus.s_fork_in_tdata;
        end
    end

    // Value FIFO pointers and occupancy; the head pops only when the item retires
    always_ff @(posedge clk) begin
        if (rst) begin
            val_wr_r  <= {AW{1'b0}};
            val_rd_r  <= {AW{1'b0}};
            val_cnt_r <= {CW{1'b0}};
        end else begin
            if (val_push_s) begin
                val_wr_r <= ptr_next(val_wr_r);
            end
            if (retire_s) begin
                val_rd_r <= ptr_next(val_rd_r);
            end
            val_cnt_r <= cnt_next(val_cnt_r, val_push_s, retire_s);
        end
    end

    generate
        if (IF_PRED_IN != 0) begin : g_pred_fifo
            logic [PORT_COUNT-1:0] pred_mem_r [FIFO_SIZE];
            logic [AW-1:0]         pred_wr_r;
            logic [AW-1:0]         pred_rd_r;
            logic [CW-1:0]         pred_cnt_r;
            logic                  pred_ready_s;
            logic                  pred_push_s;

            assign pred_ready_s         = (pred_cnt_r != CNT_FULL);
            assign bus.s_pred_in_tready = pred_ready_s;
            assign pred_push_s          = bus.s_pred_in_tvalid & pred_ready_s;
            assign pred_head_valid_s    = (pred_cnt_r != {CW{1'b0}});
            assign pred_head_s          = pred_mem_r[pred_rd_r];

            // Predicate FIFO storage write
            always_ff @(posedge clk) begin
                if (pred_push_s) begin
                    pred_mem_r[pred_wr_r] <= bus.s_pred_in_tdata;
                end
            end

            // Predicate FIFO pointers and occupancy, popped together with the value head
            always_ff @(posedge clk) begin
                if (rst) begin
                    pred_wr_r  <= {AW{1'b0}};
                    pred_rd_r  <= {AW{1'b0}};
                    pred_cnt_r <= {CW{1'b0}};
                end else begin
                    if (pred_push_s) begin
                        pred_wr_r <= ptr_next(pred_wr_r);
                    end
                    if (retire_s) begin
                        pred_rd_r <= ptr_next(pred_rd_r);
                    end
                    pred_cnt_r <= cnt_next(pred_cnt_r, pred_push_s, retire_s);
                end
            end
        end else begin : g_pred_bcast
            assign bus.s_pred_in_tready = 1'b1;
            assign pred_head_valid_s    = 1'b1;
            assign pred_head_s          = {PORT_COUNT{1'b1}};
        end
    endgenerate

    // Ports already served for the current item are masked out of pend
    assign join_valid_s          = val_head_valid_s & pred_head_valid_s;
    assign pend_s                = pred_head_s & ~done_r;
    assign bus.m_fork_out_tvalid = {PORT_COUNT{join_valid_s}} & pend_s;
    assign bus.m_fork_out_tdata  = {PORT_COUNT{val_head_s}};
    assign retire_s              = join_valid_s &
                                   ((pend_s & ~bus.m_fork_out_tready) == {PORT_COUNT{1'b0}});

    // Record early acceptors so a stalled item is never re-sent to them
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= {PORT_COUNT{1'b0}};
        end else if (retire_s) begin
            done_r <= {PORT_COUNT{1'b0}};
        end else if (join_valid_s) begin
            done_r <= done_r | (pend_s & bus.m_fork_out_tready);
        end else begin
            done_r <= done_r;
        end
    end

    // Saturating count of items retired with nothing selected
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 32'd0;
        end else if (retire_s && (pend_s == {PORT_COUNT{1'b0}}) && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end else begin
            drop_count <= drop_count;
        end
    end
endmodule

// File: doc/pred_fork.md
Name: pred_fork

Overview:
- Data-steering counterpart to the predicate-combining demux in the ep2 runtime library.
- Joins one value stream with one predicate-bitmask stream, then forks each value to every output port whose predicate bit is set.
- Sits downstream of predicate generation.
- Each output is an AXI-stream-like port feeding a per-branch handler.
- Uses eager fork semantics: ports that accept early are never re-sent the same item.

Parameters:
- VAL_WIDTH, 32, width of each value beat.
- PORT_COUNT, 2, number of output ports and width of the predicate bitmask.
- IF_PRED_IN, 1, 1 = predicate stream is used; 0 = predicate treated as all-ones (broadcast).
- FIFO_SIZE, 16, depth of each input axis_fifo.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_pred_in_tdata  in  PORT_COUNT  predicate bitmask; bit i selects output i.
- s_pred_in_tvalid  in  1  predicate valid.
- s_pred_in_tready  out  1  predicate ready.
- s_fork_in_tdata  in  VAL_WIDTH  value to distribute.
- s_fork_in_tvalid  in  1  value valid.
- s_fork_in_tready  out  1  value ready.
- m_fork_out_tdata  out  PORT_COUNT*VAL_WIDTH  per-port value; slice i is [i*VAL_WIDTH +: VAL_WIDTH].
- m_fork_out_tvalid  out  PORT_COUNT  per-port valid.
- m_fork_out_tready  in  PORT_COUNT  per-port ready.
- drop_count  out  32  number of items retired with an all-zero predicate.

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high.

Input buffering:
- Value stream passes through an axis_fifo (DEPTH=FIFO_SIZE, DATA_WIDTH=VAL_WIDTH, no last/id/dest/user, FRAME_FIFO=0).
- Predicate stream passes through a second axis_fifo (DATA_WIDTH=PORT_COUNT).
- s_*_tready equals the respective FIFO s_axis_tready.
- IF_PRED_IN=0: no predicate FIFO; s_pred_in_tready tied 1; pred_head = all-ones; pred head always valid.

Join:
- join_valid = value FIFO head valid AND predicate FIFO head valid.
- Streams pair strictly in arrival order (n-th value with n-th predicate).

Fork state:
- done register, PORT_COUNT bits; records ports that have already accepted the current item.
- pend = pred_head & ~done.
- m_fork_out_tvalid[i] = join_valid & pend[i].
- Every tdata slice = value FIFO head; slices are driven even when the port is invalid.
- A port's valid, once asserted, stays high with stable data until that port handshakes.

Retire condition:
- retire = join_valid & ((pend & ~m_fork_out_tready) == 0).
- On retire: both FIFO heads pop in the same cycle; done <= 0.
- Otherwise, when join_valid: done <= done | (pend & m_fork_out_tready).
- When join_valid is low, done holds.

Timing:
- An item with all selected ports ready retires in the cycle it presents: one handshake per selected port, that same cycle.
- Throughput is 1 item/cycle when all selected ports are ready.
- Latency = axis_fifo read latency; no extra pipeline register.

Zero predicate:
- pend == 0 → retire immediately with no output valid.
- drop_count += 1, saturating at 0xFFFFFFFF.

Boundaries:
- Input FIFO full: corresponding s_*_tready low; no data loss.
- One stream arriving ahead of the other: it waits in its FIFO, no output.
- Ports not selected by the predicate never see valid.
- Reset mid-item (done != 0): done cleared, FIFOs flushed, partially delivered item discarded.

Reset values:
- m_fork_out_tvalid = 0.
- s_*_tready per axis_fifo reset (high once out of reset).
- done = 0.
- drop_count = 0.
- m_fork_out_tdata don't-care.

Test Plan:
- PORT_COUNT=2, pred=2'b11, value 0xA5A5A5A5, both ready high → both valid in same cycle, one handshake each, both slices 0xA5A5A5A5, item retires, drop_count stays 0.
- pred=2'b11, port0 ready, port1 ready low for 3 cycles → port0 exactly one handshake then valid low; port1 valid held 3 cycles, accepted on cycle 4; next item (pred=01, 0x1) appears on port0 only after that.
- pred=2'b00 with value 0x7 → no output valid; drop_count 0→1; both FIFOs pop. Repeat 3 times → drop_count=3.
- Values 0x1..0x5 sent 5 cycles before preds 01,10,11,01,10 → no output until the first pred arrives; then in-order fork: port0 gets 1,3,4; port1 gets 2,3,5.
- FIFO_SIZE=16, 17 value beats, no preds → s_fork_in_tready low after 16 accepted; one pred=01 then frees one slot.
- Same partial state as the second scenario (port0 accepted, port1 stalled), assert rst 1 cycle → next cycle m_fork_out_tvalid=0, done=0, drop_count=0; new pred/value pair forks normally.
